lock_access_ctrl: RTL
=====================

Name: lock_access_ctrl

Overview:
Front-end controller for lockeddoor. It arbitrates keystrokes from two keypads (outer keypad A, inner panel B) and replays each accepted key to lockeddoor's inputChar as a clean fixed-length strobe. It watches lockeddoor's open output to drive the door relay, counts failed attempts, and enforces a lockout period after too many failures.

Parameters:
KEY_HOLD, 10, cycles each forwarded key is held on lock_char
KEY_GAP, 10, cycles lock_char is held at zero after each strobe
PW_LEN, 6, digits per password
CHECK_WIN, 16, cycles to wait for lock_open after the last digit
RELAY_CYC, 100, cycles the relay is held on
MAX_FAIL, 3, consecutive failures that trigger lockout
LOCK_CYC, 1000, lockout duration in cycles
IDLE_TO, 500, inter-key idle timeout in cycles

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
key_a  in  12  keypad A, one-hot, level while held (bit0..9 = digits 0-9, bit10 = *, bit11 = #)
key_b  in  12  keypad B, same encoding as key_a
lock_open  in  1  open output from lockeddoor
lock_char  out  12  drives lockeddoor inputChar
relay  out  1  door relay drive
lockout  out  1  high during lockout
owner  out  1  0 = A owns the session, 1 = B owns the session; valid while busy
busy  out  1  high while a session is active
fail_cnt  out  2  consecutive failure count

Behaviour:
- Reset (asynchronous, takes effect immediately): all outputs 0, state IDLE, pending buffer empty, all counters 0.
- Key detect: a press is a registered rising edge, from all-zero to exactly one bit set. Multi-bit codes and held keys are ignored. Detection is 1 cycle late relative to the input.
- Arbitration: in IDLE, the first keypad with a press becomes owner. If both press in the same cycle, A wins. Presses from the non-owner are discarded for the whole session.
- Pending buffer: one entry deep. A press arriving while the entry is full is dropped.
- Session type is set by the first key:
  - digit: normal session of PW_LEN digits.
  - *: change session, * followed by 2*PW_LEN digits.
  - # as first key: ignored; stay in IDLE.
- Forwarding: a key leaves the buffer, then lock_char equals the code for exactly KEY_HOLD cycles (FWD_HOLD), then 0 for KEY_GAP cycles (FWD_GAP). Successive keys are never back-to-back.
- States:
  - IDLE -> FWD_HOLD on an accepted key.
  - FWD_HOLD -> FWD_GAP after KEY_HOLD cycles.
  - FWD_GAP -> one of the following after KEY_GAP cycles:
    - CHECK if the normal-session digit count equals PW_LEN.
    - IDLE if the change-session digit count equals 2*PW_LEN; fail_cnt unchanged.
    - IDLE if the forwarded key was #; this is an abort with no fail counted.
    - FWD_HOLD if the buffer is full.
    - WAIT_KEY otherwise.
  - WAIT_KEY -> FWD_HOLD when a key is available.
  - WAIT_KEY -> timeout after IDLE_TO cycles with no key: the controller forwards # itself, then returns to IDLE; no fail counted.
  - CHECK: lock_open sampled for up to CHECK_WIN cycles.
    - If seen: RELAY, fail_cnt := 0.
    - If not seen: fail_cnt += 1. If the new count equals MAX_FAIL, go to LOCKOUT; else go to IDLE.
  - RELAY: relay=1 for RELAY_CYC cycles, then IDLE.
  - LOCKOUT: lockout=1 for LOCK_CYC cycles. All keys are discarded and the buffer is cleared. Then IDLE with fail_cnt := 0.
- lock_open outside CHECK is ignored; relay never asserts outside RELAY.
- busy=1 in every state except IDLE and LOCKOUT. owner is held for the whole session.
- fail_cnt saturates at MAX_FAIL and never wraps.

Test Plan:
1. Reset is asserted while lock_char=CHR_3 in FWD_HOLD -> lock_char=0, busy=0, and relay=0 in the same cycle, with no clock edge needed.
2. Keypad A presses 1,2,3,4,5,6 and the model raises lock_open 2 cycles after the 6th strobe -> six 10-cycle strobes spaced 20 cycles apart, then relay=1 for exactly 100 cycles, fail_cnt=0.
3. key_a=CHR_1 and key_b=CHR_9 go high in the same cycle -> owner=0, lock_char=CHR_1, and every B press during the session is discarded.
4. Three wrong 6-digit entries with lock_open never asserted -> fail_cnt goes 1, 2, then lockout=1 for 1000 cycles. A press of 5 during lockout produces no strobe. After lockout, fail_cnt=0.
5. Inputs 1, 2, # -> three strobes, return to IDLE, fail_cnt unchanged. Then 1 followed by 500 idle cycles -> the controller emits a CHR_p strobe and returns to IDLE.
6. * followed by 123456 and 135790 -> 13 strobes in order, no CHECK state and no relay; an input of 0x003 (two bits set) is ignored.

Source files
------------

// File: rtl/lock_access_ctrl.sv
// lock_access_ctrl
// Front-end controller for lockeddoor. Arbitrates keystrokes from two keypads,
// replays each accepted key to lockeddoor as a fixed-length strobe, drives the
// door relay when lockeddoor opens, counts failed attempts and enforces a
// lockout period after too many consecutive failures.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   key_a      keypad A, one-hot level code (bit0..9 digits, bit10 '*', bit11 '#')
//   key_b      keypad B, same encoding as key_a
//   lock_open  open output from lockeddoor, only looked at while checking
//   lock_char  key code forwarded to lockeddoor inputChar
//   relay      door relay drive
//   lockout    high during the lockout period
//   owner      0 = keypad A owns the session, 1 = keypad B (valid while busy)
//   busy       high while a session is active
//   fail_cnt   consecutive failure count, saturating at MAX_FAIL
module lock_access_ctrl #(
  parameter int KEY_HOLD  = 10,
  parameter int KEY_GAP   = 10,
  parameter int PW_LEN    = 6,
  parameter int CHECK_WIN = 16,
  parameter int RELAY_CYC = 100,
  parameter int MAX_FAIL  = 3,
  parameter int LOCK_CYC  = 1000,
  parameter int IDLE_TO   = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] key_a,
  input  logic [11:0] key_b,
  input  logic        lock_open,
  output logic [11:0] lock_char,
  output logic        relay,
  output logic        lockout,
  output logic        owner,
  output logic        busy,
  output logic [1:0]  fail_cnt
);

  localparam int TMR_W = $clog2(LOCK_CYC + IDLE_TO + RELAY_CYC + CHECK_WIN + KEY_HOLD + KEY_GAP + 1);
  localparam int CNT_W = $clog2(2 * PW_LEN + 1);

  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(KEY_HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(KEY_GAP - 1);
  localparam logic [TMR_W-1:0] CHECK_LAST = TMR_W'(CHECK_WIN - 1);
  localparam logic [TMR_W-1:0] RELAY_LAST = TMR_W'(RELAY_CYC - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST  = TMR_W'(LOCK_CYC - 1);
  localparam logic [TMR_W-1:0] IDLE_LAST  = TMR_W'(IDLE_TO - 1);

  localparam logic [CNT_W-1:0] NORM_DONE = CNT_W'(PW_LEN);
  localparam logic [CNT_W-1:0] CHG_DONE  = CNT_W'(2 * PW_LEN);
  localparam logic [1:0]       FAIL_LIM  = 2'(MAX_FAIL);

  localparam logic [11:0] CODE_STAR = 12'h400;
  localparam logic [11:0] CODE_HASH = 12'h800;

  typedef enum logic [2:0] {
    IDLE,
    FWD_HOLD,
    FWD_GAP,
    WAIT_KEY,
    CHECK,
    RELAY,
    LOCKOUT
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [11:0]      cur_char, char_nxt;
  logic             owner_q, owner_nxt;
  logic             chg_mode, chg_nxt;
  logic [CNT_W-1:0] digit_cnt, cnt_nxt;
  logic [1:0]       fail_nxt, fail_inc;
  logic             buf_full, buf_full_nxt;
  logic [11:0]      buf_code, buf_code_nxt;

  logic [11:0] key_a_q, key_a_q2, key_b_q, key_b_q2;
  logic        press_a, press_b;
  logic [11:0] first_code;
  logic        first_ok;
  logic        own_press;
  logic [11:0] own_code;
  logic        load;
  logic [11:0] load_code;

  function automatic logic is_onehot(input logic [11:0] v);
    return (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0);
  endfunction

  // Two-stage key history: a press is the registered code becoming a single
  // bit while the stage before it was all-zero, so detection is one cycle late.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_a_q  <= '0;
      key_a_q2 <= '0;
      key_b_q  <= '0;
      key_b_q2 <= '0;
    end else begin
      key_a_q  <= key_a;
      key_a_q2 <= key_a_q;
      key_b_q  <= key_b;
      key_b_q2 <= key_b_q;
    end
  end

  assign press_a = (key_a_q2 == 12'd0) && is_onehot(key_a_q);
  assign press_b = (key_b_q2 == 12'd0) && is_onehot(key_b_q);

  // A wins a same-cycle tie; a leading '#' is never a session opener.
  assign first_code = press_a ? key_a_q : key_b_q;
  assign first_ok   = (press_a || press_b) && (first_code != CODE_HASH);

  assign own_press = owner_q ? press_b : press_a;
  assign own_code  = owner_q ? key_b_q : key_a_q;

  // State register and session bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      cur_char  <= '0;
      owner_q   <= 1'b0;
      chg_mode  <= 1'b0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      buf_full  <= 1'b0;
      buf_code  <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      cur_char  <= char_nxt;
      owner_q   <= owner_nxt;
      chg_mode  <= chg_nxt;
      digit_cnt <= cnt_nxt;
      fail_cnt  <= fail_nxt;
      buf_full  <= buf_full_nxt;
      buf_code  <= buf_code_nxt;
    end
  end

  // Next-state logic. Every entry into FWD_HOLD goes through 'load' so the
  // strobe timer, forwarded code and digit count are updated in one place.
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer + 1'b1;
    char_nxt     = cur_char;
    owner_nxt    = owner_q;
    chg_nxt      = chg_mode;
    cnt_nxt      = digit_cnt;
    fail_nxt     = fail_cnt;
    buf_full_nxt = buf_full;
    buf_code_nxt = buf_code;
    load         = 1'b0;
    load_code    = '0;
    fail_inc     = (fail_cnt < FAIL_LIM) ? fail_cnt + 2'd1 : fail_cnt;

    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (first_ok) begin
          load      = 1'b1;
          load_code = first_code;
          owner_nxt = !press_a;
          chg_nxt   = (first_code == CODE_STAR);
          cnt_nxt   = '0;
        end
      end

      FWD_HOLD: begin
        if (timer == HOLD_LAST) begin
          state_nxt = FWD_GAP;
          timer_nxt = '0;
        end
      end

      FWD_GAP: begin
        if (timer == GAP_LAST) begin
          timer_nxt = '0;
          if (!chg_mode && (digit_cnt == NORM_DONE)) begin
            state_nxt = CHECK;
          end else if (chg_mode && (digit_cnt == CHG_DONE)) begin
            state_nxt = IDLE;
          end else if (cur_char == CODE_HASH) begin
            state_nxt = IDLE;
          end else if (buf_full) begin
            load         = 1'b1;
            load_code    = buf_code;
            buf_full_nxt = 1'b0;
          end else begin
            state_nxt = WAIT_KEY;
          end
        end
      end

      WAIT_KEY: begin
        if (buf_full) begin
          load         = 1'b1;
          load_code    = buf_code;
          buf_full_nxt = 1'b0;
        end else if (timer == IDLE_LAST) begin
          // Abandoned entry: close it on lockeddoor's side with a '#'.
          load      = 1'b1;
          load_code = CODE_HASH;
        end
      end

      CHECK: begin
        if (lock_open) begin
          state_nxt = RELAY;
          timer_nxt = '0;
          fail_nxt  = '0;
        end else if (timer == CHECK_LAST) begin
          timer_nxt = '0;
          fail_nxt  = fail_inc;
          state_nxt = (fail_inc == FAIL_LIM) ? LOCKOUT : IDLE;
        end
      end

      RELAY: begin
        if (timer == RELAY_LAST) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end
      end

      LOCKOUT: begin
        if (timer == LOCK_LAST) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          fail_nxt  = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase

    if (load) begin
      state_nxt = FWD_HOLD;
      timer_nxt = '0;
      char_nxt  = load_code;
      if (|load_code[9:0]) begin
        cnt_nxt = cnt_nxt + 1'b1;
      end
    end

    // Owner keys are buffered only while keys are still being forwarded; a
    // press arriving while the entry is occupied is lost.
    if (((state == FWD_HOLD) || (state == FWD_GAP) || (state == WAIT_KEY)) &&
        own_press && !buf_full) begin
      buf_full_nxt = 1'b1;
      buf_code_nxt = own_code;
    end

    // Leaving the forwarding phase discards anything still buffered.
    if (!((state_nxt == FWD_HOLD) || (state_nxt == FWD_GAP) || (state_nxt == WAIT_KEY))) begin
      buf_full_nxt = 1'b0;
    end
  end

  assign lock_char = (state == FWD_HOLD) ? cur_char : 12'd0;
  assign relay     = (state == RELAY);
  assign lockout   = (state == LOCKOUT);
  assign busy      = (state != IDLE) && (state != LOCKOUT);
  assign owner     = owner_q;

endmodule
